// File: rtl/serial_dot_engine.sv
// Element-serial vector engine: accumulates a*b (dot product) or |a-b| (SAD)
// over LEN element pairs, one pair per cycle, with a saturating accumulator.
module serial_dot_engine #(
    parameter int LEN   = 6,
    parameter int EW    = 1,
    parameter int ACC_W = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic [LEN*EW-1:0]  i_a_vec,
    input  logic [LEN*EW-1:0]  i_b_vec,
    output logic               o_busy,
    output logic               o_done,
    output logic [ACC_W-1:0]   o_result,
    output logic               o_ovf
);

    // state  | meaning
    // IDLE   | waiting for start
    // RUN    | consuming one element pair per cycle, LEN cycles
    // DONE   | one-cycle done pulse; start here reloads back-to-back
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int IW = $clog2(LEN);
    localparam int TW = 2 * EW;
    // One bit wider than the larger operand so acc + term never wraps.
    localparam int SW = ((ACC_W > TW) ? ACC_W : TW) + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LEN*EW-1:0]   r_a_sh;
    logic [LEN*EW-1:0]   r_b_sh;
    logic                r_mode;
    logic [ACC_W-1:0]    r_acc;
    logic                r_sat;
    logic [IW-1:0]       r_idx;
    logic [ACC_W-1:0]    r_result;
    logic                r_ovf;

    logic                w_load;
    logic                w_last;
    logic [EW-1:0]       w_a;
    logic [EW-1:0]       w_b;
    logic [EW-1:0]       w_diff;
    logic [TW-1:0]       w_term;
    logic [SW-1:0]       w_sum;
    logic [ACC_W-1:0]    w_max;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic                w_sat_nxt;

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        w_load      = 1'b0;
        w_last      = (r_idx == IW'(LEN - 1));
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_a       = r_a_sh[EW-1:0];
        w_b       = r_b_sh[EW-1:0];
        w_diff    = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
        w_term    = r_mode ? TW'(w_diff) : (TW'(w_a) * TW'(w_b));
        w_sum     = SW'(r_acc) + SW'(w_term);
        w_max     = {ACC_W{1'b1}};
        w_acc_nxt = w_sum[ACC_W-1:0];
        w_sat_nxt = r_sat;
        if (w_sum > SW'(w_max)) begin
            w_acc_nxt = w_max;
            w_sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_mode   <= 1'b0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_a_sh <= i_a_vec;
                r_b_sh <= i_b_vec;
                r_mode <= i_mode;
                r_acc  <= '0;
                r_sat  <= 1'b0;
                r_idx  <= '0;
            end else if (r_state == S_RUN) begin
                r_a_sh <= r_a_sh >> EW;
                r_b_sh <= r_b_sh >> EW;
                r_acc  <= w_acc_nxt;
                r_sat  <= w_sat_nxt;
                r_idx  <= r_idx + IW'(1);
                // Publish on the RUN->DONE edge so result is visible during DONE.
                if (w_last) begin
                    r_result <= w_acc_nxt;
                    r_ovf    <= w_sat_nxt;
                end
            end
        end
    end

    assign o_result = r_result;
    assign o_ovf    = r_ovf;

endmodule
